// File: rtl/pdm_pkg.sv
// Shared types and constants for the PDM transmitter.
package pdm_pkg;

  localparam int unsigned PCM_W = 16;
  localparam int unsigned ACC_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Control commands; bit 0 set means stop (2'b01 and 2'b11 are equivalent).
  localparam logic [1:0] CTRL_NOP      = 2'b00;
  localparam logic [1:0] CTRL_STOP     = 2'b01;
  localparam logic [1:0] CTRL_START    = 2'b10;
  localparam logic [1:0] CTRL_STOP_ALT = 2'b11;

  // Modulator feedback levels (full scale of a 16-bit sample).
  localparam logic signed [ACC_W-1:0] FS_POS = 24'sd32767;
  localparam logic signed [ACC_W-1:0] FS_NEG = -24'sd32768;

  // Integrator limits and their widened forms for overflow-free compares.
  localparam logic signed [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W - 1){1'b0}}};
  localparam logic signed [ACC_W+1:0] ACC_MAX_W = (ACC_W + 2)'(ACC_MAX);
  localparam logic signed [ACC_W+1:0] ACC_MIN_W = (ACC_W + 2)'(ACC_MIN);

  // Clamp a widened integrator sum back into ACC_W bits.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W+1:0] v);
    if (v > ACC_MAX_W) begin
      return ACC_MAX;
    end else if (v < ACC_MIN_W) begin
      return ACC_MIN;
    end
    return v[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/pdm_tx_if.sv
// Control, PCM stream and PDM output signals of the PDM transmitter.
interface pdm_tx_if;
  import pdm_pkg::*;

  logic [1:0]       ctrl;
  logic [PCM_W-1:0] pcm_data;
  logic             pcm_valid;
  logic             pcm_ready;
  logic             pdm_clk;
  logic             pdm_signal;
  logic             bsy;
  logic             underrun;

  modport master (
    output ctrl, pcm_data, pcm_valid,
    input  pcm_ready, pdm_clk, pdm_signal, bsy, underrun
  );

  modport slave (
    input  ctrl, pcm_data, pcm_valid,
    output pcm_ready, pdm_clk, pdm_signal, bsy, underrun
  );

endinterface

// File: rtl/pdm_tx_fifo.sv
// Synchronous show-ahead sample FIFO; DEPTH must be a power of two.
module pdm_tx_fifo
  import pdm_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [PCM_W-1:0] wdata,
  output logic [PCM_W-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PCM_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW + 1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  // A pop frees the slot, so a push is accepted even when full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_q];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_q] <= wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pdm_tx.sv
// PDM transmitter: PCM FIFO, pdm_clk divider and second-order sigma-delta modulator.
// Optional build macro PDM_TX_DITHER_EN adds a 1-LSB LFSR dither to each sample.
module pdm_tx
  import pdm_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 33,
  parameter int unsigned OSR        = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic     AHBclk,
  input logic     rst,
  pdm_tx_if.slave bus
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);

  state_e                   state_q, state_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [BIT_W-1:0]         bit_q, bit_d;
  logic                     pclk_q, pclk_d;
  logic                     psig_q, psig_d;
  logic                     under_q, under_d;
  logic                     rdy_q;
  logic signed [ACC_W-1:0]  int1_q, int1_d, int2_q, int2_d;
  logic signed [PCM_W-1:0]  x_q, x_d;

  logic                     cmd_start, cmd_stop;
  logic                     tc, fall, boundary;
  logic                     push, pop;
  logic [PCM_W-1:0]         fifo_rdata;
  logic                     fifo_full, fifo_empty;
  logic signed [PCM_W-1:0]  x_cur;
  logic signed [ACC_W+1:0]  x_w, y_w, sum1, sum2;
  logic signed [ACC_W-1:0]  int1_n, int2_n;

  assign cmd_start = (bus.ctrl == CTRL_START);
  assign cmd_stop  = bus.ctrl[0];
  assign tc        = (state_q != IDLE) && (div_q == DIV_LAST);
  // Modulator steps when pdm_clk is about to fall.
  assign fall      = tc && pclk_q;
  assign boundary  = (bit_q == '0);
  assign pop       = fall && boundary && !fifo_empty;
  assign push      = bus.pcm_valid && bus.pcm_ready;

  assign bus.pcm_ready  = rdy_q && !fifo_full;
  assign bus.pdm_clk    = pclk_q;
  assign bus.pdm_signal = psig_q;
  assign bus.bsy        = (state_q != IDLE);
  assign bus.underrun   = under_q;

  pdm_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (AHBclk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata(bus.pcm_data),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

`ifdef PDM_TX_DITHER_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign x_w     = (ACC_W + 2)'(x_cur) + (ACC_W + 2)'(lfsr_q[0]);

  // Dither LFSR, advanced once per modulator step.
  always_ff @(posedge AHBclk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= 16'hACE1;
    end else if (fall) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end
`else
  assign x_w = (ACC_W + 2)'(x_cur);
`endif

  // Modulator arithmetic for the current step.
  always_comb begin
    x_cur = x_q;
    if (boundary) begin
      x_cur = fifo_empty ? '0 : $signed(fifo_rdata);
    end
    y_w    = int2_q[ACC_W-1] ? (ACC_W + 2)'(FS_NEG) : (ACC_W + 2)'(FS_POS);
    sum1   = (ACC_W + 2)'(int1_q) + x_w - y_w;
    int1_n = sat_acc(sum1);
    sum2   = (ACC_W + 2)'(int2_q) + (ACC_W + 2)'(int1_n) - y_w;
    int2_n = sat_acc(sum2);
  end

  // Run-state sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_start) state_d = RUN;
      RUN:     if (cmd_stop) state_d = DRAIN;
      DRAIN: begin
        if (cmd_start) begin
          state_d = RUN;
        end else if (fall && (bit_q == BIT_LAST)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Divider, modulator and status next-state.
  always_comb begin
    div_d   = div_q;
    bit_d   = bit_q;
    pclk_d  = pclk_q;
    psig_d  = psig_q;
    int1_d  = int1_q;
    int2_d  = int2_q;
    x_d     = x_q;
    under_d = under_q;

    if ((state_q == IDLE) || (state_d == IDLE)) begin
      div_d  = '0;
      bit_d  = '0;
      pclk_d = 1'b0;
      psig_d = 1'b0;
      int1_d = '0;
      int2_d = '0;
      x_d    = '0;
    end else begin
      div_d = tc ? '0 : div_q + 1'b1;
      if (tc) pclk_d = !pclk_q;
      if (fall) begin
        psig_d = !int2_q[ACC_W-1];
        int1_d = int1_n;
        int2_d = int2_n;
        bit_d  = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
        if (boundary) x_d = x_cur;
      end
    end

    // A fresh underrun outranks the clear from a simultaneous restart.
    if (cmd_start && (state_q != RUN)) under_d = 1'b0;
    if (fall && boundary && fifo_empty) under_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge AHBclk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      pclk_q  <= 1'b0;
      psig_q  <= 1'b0;
      int1_q  <= '0;
      int2_q  <= '0;
      x_q     <= '0;
      under_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      pclk_q  <= pclk_d;
      psig_q  <= psig_d;
      int1_q  <= int1_d;
      int2_q  <= int2_d;
      x_q     <= x_d;
      under_q <= under_d;
      rdy_q   <= 1'b1;
    end
  end

endmodule
